// File: rtl/loby_sponge_ctrl.sv
// Sponge-style controller: absorbs 2-bit-symbol-encoded blocks into a state register
// and drives an external combinational permutation for ROUNDS rounds per operation.
module loby_sponge_ctrl #(
  parameter int STATE_W = 257,
  parameter int RATE_W  = 64,
  parameter int ROUNDS  = 1
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               init,
  input  logic [STATE_W-1:0] key,
  input  logic [RATE_W-1:0]  din,
  input  logic               din_valid,
  input  logic               din_last,
  output logic               din_ready,
  input  logic               sqz_req,
  output logic [STATE_W-1:0] dout,
  output logic               dout_valid,
  output logic               busy,
  output logic [STATE_W-1:0] perm_in,
  input  logic [STATE_W-1:0] perm_out
);

  localparam int HALF  = RATE_W / 2;
  localparam int CNT_W = $clog2(ROUNDS) + 1;

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t               fsm;
  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] work;
  logic [CNT_W-1:0]   cnt;
  logic               sqz_op;

  logic [3:0][HALF-1:0] lane;
  logic [STATE_W-1:0]   absorb_op;
  logic [STATE_W-1:0]   perm_res;
  logic                 last_round;

  // Each 2-bit symbol {a,b} becomes a one-hot select of lane 2*a+b at the pair's position.
  always_comb begin
    // NOTE: every variable gets a default before any conditional/loop update so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    lane      = '0;
    absorb_op = state_reg;
    for (int i = 0; i < HALF; i++) begin
      lane[0][i] = ~din[2*i] & ~din[2*i+1];
      lane[1][i] = ~din[2*i] &  din[2*i+1];
      lane[2][i] =  din[2*i] & ~din[2*i+1];
      lane[3][i] =  din[2*i] &  din[2*i+1];
    end
    for (int k = 0; k < 4; k++)
      absorb_op[k*HALF +: HALF] = absorb_op[k*HALF +: HALF] ^ lane[k];
    absorb_op[STATE_W-1] = absorb_op[STATE_W-1] ^ din_last;
  end

  assign perm_res   = perm_out ^ work;
  assign last_round = (cnt == CNT_W'(ROUNDS - 1));
  assign perm_in    = work;
  assign busy       = (fsm == RUN);
  assign din_ready  = (fsm == IDLE) & ~init;

  always_ff @(posedge clk or posedge arstn) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (arstn) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      work       <= '0;
      cnt        <= '0;
      sqz_op     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (init) begin
            work   <= key;
            sqz_op <= 1'b0;
            cnt    <= '0;
            fsm    <= RUN;
          end else if (din_valid) begin
            work   <= absorb_op;
            sqz_op <= 1'b0;
            cnt    <= '0;
            fsm    <= RUN;
          end else if (sqz_req) begin
            work   <= state_reg;
            sqz_op <= 1'b1;
            cnt    <= '0;
            fsm    <= RUN;
          end
        end
        RUN: begin
          if (init) begin
            // Abort restarts from the key; the aborted result is never published.
            work   <= key;
            sqz_op <= 1'b0;
            cnt    <= '0;
          end else begin
            work <= perm_res;
            cnt  <= cnt + 1'b1;
            if (last_round) begin
              state_reg <= perm_res;
              fsm       <= IDLE;
              if (sqz_op) begin
                dout       <= perm_res;
                dout_valid <= 1'b1;
              end
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loby_sponge_ctrl.sv
// Bench: two controllers (ROUNDS=1 and ROUNDS=2) on shared stimulus, checked every
// cycle against an operation-level model plus directed literal expectations.
module tb_loby_sponge_ctrl;

  localparam int SW = 17;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic          init, din_valid, din_last, sqz_req;
  logic [SW-1:0] key;
  logic [RW-1:0] din;
  int            perm_sel;

  logic [SW-1:0] dout_o [2];
  logic [SW-1:0] pin_o  [2];
  logic [SW-1:0] pout_i [2];
  logic          busy_o [2];
  logic          rdy_o  [2];
  logic          dv_o   [2];

  int total = 0;
  int bad   = 0;
  int dv_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] rotl(input logic [SW-1:0] w, input int n);
    return (w << n) | (w >> (SW - n));
  endfunction

  function automatic logic [SW-1:0] perm_fn(input int sel, input logic [SW-1:0] w);
    case (sel)
      1:       return rotl(w, 1);
      2:       return rotl(w, 1) ^ (rotl(w, 5) & ~w) ^ 17'h0A5C3;
      default: return '0;
    endcase
  endfunction

  // Result of k rounds of w <- P(w) ^ w.
  function automatic logic [SW-1:0] iter(input int sel, input logic [SW-1:0] x, input int k);
    logic [SW-1:0] w = x;
    for (int j = 0; j < k; j++) w = perm_fn(sel, w) ^ w;
    return w;
  endfunction

  function automatic logic [SW-1:0] absorb(input logic [SW-1:0] s, input logic [RW-1:0] d,
                                           input logic last);
    logic [SW-1:0] r = s;
    for (int i = 0; i < RW/2; i++) begin
      int sym = 2 * int'(d[2*i]) + int'(d[2*i+1]);
      r[sym*(RW/2) + i] = ~r[sym*(RW/2) + i];
    end
    r[SW-1] = r[SW-1] ^ last;
    return r;
  endfunction

  loby_sponge_ctrl #(.STATE_W(SW), .RATE_W(RW), .ROUNDS(1)) u_r1 (
    .clk(clk), .arstn(arstn), .init(init), .key(key), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(rdy_o[0]), .sqz_req(sqz_req), .dout(dout_o[0]),
    .dout_valid(dv_o[0]), .busy(busy_o[0]), .perm_in(pin_o[0]), .perm_out(pout_i[0]));

  loby_sponge_ctrl #(.STATE_W(SW), .RATE_W(RW), .ROUNDS(2)) u_r2 (
    .clk(clk), .arstn(arstn), .init(init), .key(key), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(rdy_o[1]), .sqz_req(sqz_req), .dout(dout_o[1]),
    .dout_valid(dv_o[1]), .busy(busy_o[1]), .perm_in(pin_o[1]), .perm_out(pout_i[1]));

  assign pout_i[0] = perm_fn(perm_sel, pin_o[0]);
  assign pout_i[1] = perm_fn(perm_sel, pin_o[1]);

  // Operation-level model: start value x plus rounds done k; result computed by iter().
  logic          m_busy  [2];
  int            m_k     [2];
  logic [SW-1:0] m_x     [2];
  logic          m_sqz   [2];
  logic [SW-1:0] m_state [2];
  logic [SW-1:0] m_dout  [2];
  logic          m_dv    [2];

  always @(posedge clk or posedge arstn) begin
    if (arstn) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_k[i] <= 0; m_x[i] <= '0; m_sqz[i] <= 1'b0;
        m_state[i] <= '0; m_dout[i] <= '0; m_dv[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_dv[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (init) begin
            m_x[i] <= key; m_k[i] <= 0; m_sqz[i] <= 1'b0; m_busy[i] <= 1'b1;
          end else if (din_valid) begin
            m_x[i] <= absorb(m_state[i], din, din_last); m_k[i] <= 0;
            m_sqz[i] <= 1'b0; m_busy[i] <= 1'b1;
          end else if (sqz_req) begin
            m_x[i] <= m_state[i]; m_k[i] <= 0; m_sqz[i] <= 1'b1; m_busy[i] <= 1'b1;
          end
        end else if (init) begin
          m_x[i] <= key; m_k[i] <= 0; m_sqz[i] <= 1'b0;
        end else begin
          m_k[i] <= m_k[i] + 1;
          if (m_k[i] + 1 == i + 1) begin
            m_busy[i]  <= 1'b0;
            m_state[i] <= iter(perm_sel, m_x[i], i + 1);
            if (m_sqz[i]) begin
              m_dout[i] <= iter(perm_sel, m_x[i], i + 1);
              m_dv[i]   <= 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dv_o[i] === 1'b1) dv_cnt[i]++;
      if (!arstn) begin
        check($sformatf("busy[%0d]", i), busy_o[i], m_busy[i]);
        check($sformatf("din_ready[%0d]", i), rdy_o[i], !m_busy[i] && !init);
        check($sformatf("perm_in[%0d]", i), pin_o[i], iter(perm_sel, m_x[i], m_k[i]));
        check($sformatf("dout_valid[%0d]", i), dv_o[i], m_dv[i]);
        check($sformatf("dout[%0d]", i), dout_o[i], m_dout[i]);
      end
    end
  end

  task automatic clear_inputs();
    init = 1'b0; din_valid = 1'b0; sqz_req = 1'b0; din_last = 1'b0; din = '0; key = '0;
  endtask

  task automatic apply_reset(input int sel);
    arstn = 1'b1;
    clear_inputs();
    perm_sel = sel;
    @(posedge clk); @(posedge clk);
    #3 arstn = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy_o[i] && n < 30) begin @(negedge clk); n++; end
    check($sformatf("idle_wait[%0d]", i), busy_o[i], 1'b0);
  endtask

  task automatic do_req(input int i, input bit ini, input logic [SW-1:0] k, input bit v,
                        input logic [RW-1:0] d, input bit l, input bit s);
    wait_idle(i);
    #1;
    init = ini; key = k; din_valid = v; din = d; din_last = l; sqz_req = s;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic await_dout(input int i, input logic [SW-1:0] exp, input string name);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      if (dv_o[i] === 1'b1) got = 1'b1;
      n++;
    end
    check({name, "_pulse"}, got, 1'b1);
    check(name, dout_o[i], exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    arstn = 1'b1;
    perm_sel = 0;
    clear_inputs();
    init = 1'b1;
    #3;
    check("rst_din_ready_init", rdy_o[0], 1'b0);
    init = 1'b0;
    #1;
    check("rst_din_ready", rdy_o[0], 1'b1);
    apply_reset(0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy_o[i], 1'b0);
      check("rst_dout", dout_o[i], '0);
      check("rst_dv", dv_o[i], 1'b0);
      check("rst_perm_in", pin_o[i], '0);
    end

    // Key load with P=0: one busy cycle, no pulse, state observable via squeeze.
    snap = dv_cnt[0];
    do_req(0, 1'b1, 17'h12345, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); check("init_busy_1st", busy_o[0], 1'b1);
    @(negedge clk); check("init_busy_2nd", busy_o[0], 1'b0);
    check("init_no_dv", dv_cnt[0], snap);
    do_req(0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(0, 17'h12345, "init_state");

    // Absorb encoding and domain-separation bit.
    apply_reset(0);
    do_req(0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    do_req(0, 1'b0, '0, 1'b1, 4'hD, 1'b0, 1'b0);
    do_req(0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(0, 17'h00090, "absorb_d");
    do_req(0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    do_req(0, 1'b0, '0, 1'b1, 4'hD, 1'b1, 1'b0);
    do_req(0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(0, 17'h10090, "absorb_d_last");

    // Two rounds of rotl1: 1 -> 3 -> 5, then squeeze 5 -> F -> 11.
    apply_reset(1);
    do_req(1, 1'b1, 17'h00001, 1'b0, '0, 1'b0, 1'b0);
    wait_idle(1);
    check("multi_round_state", pin_o[1], 17'h00005);
    do_req(1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(1, 17'h00011, "multi_round_sqz");

    // Backpressure: din_valid held through RUN yields exactly one absorb.
    apply_reset(0);
    do_req(0, 1'b1, 17'h00100, 1'b0, '0, 1'b0, 1'b0);
    din_valid = 1'b1; din = 4'h6;
    @(negedge clk); check("bp_not_ready", rdy_o[0], 1'b0);
    @(posedge clk); @(posedge clk); #1;
    din_valid = 1'b0;
    do_req(0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(0, 17'h00124, "bp_single_absorb");

    // Abort a squeeze with init: no pulse, result derived from the key.
    apply_reset(1);
    snap = dv_cnt[1];
    do_req(1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    init = 1'b1; key = 17'h00040;
    @(posedge clk); #1;
    clear_inputs();
    wait_idle(1);
    @(negedge clk);
    check("abort_no_dv", dv_cnt[1], snap);
    check("abort_state", pin_o[1], 17'h00140);
    do_req(1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(1, 17'h00440, "abort_sqz");

    // Absorb beats a simultaneous squeeze; held squeeze is served afterwards.
    apply_reset(0);
    wait_idle(0);
    #1;
    din_valid = 1'b1; din = 4'hD; sqz_req = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    await_dout(0, 17'h00090, "prio_absorb_first");
    clear_inputs();

    // Asynchronous reset in the middle of a squeeze.
    apply_reset(1);
    do_req(1, 1'b1, 17'h1ABCD, 1'b0, '0, 1'b0, 1'b0);
    do_req(1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    await_dout(1, iter(1, iter(1, 17'h1ABCD, 2), 2), "pre_rst_sqz");
    do_req(1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    #2 arstn = 1'b1;
    #1;
    check("midrst_busy", busy_o[1], 1'b0);
    check("midrst_dout", dout_o[1], '0);
    check("midrst_dv", dv_o[1], 1'b0);
    check("midrst_perm_in", pin_o[1], '0);
    #3 arstn = 1'b0;
    snap = dv_cnt[1];
    repeat (6) @(negedge clk);
    check("midrst_no_dv", dv_cnt[1], snap);

    // Randomized traffic for both permutations.
    for (int sel = 1; sel <= 2; sel++) begin
      apply_reset(sel);
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk); #1;
        init      = ($urandom_range(0, 15) == 0);
        key       = SW'($urandom);
        din_valid = ($urandom_range(0, 1) == 1);
        din       = RW'($urandom);
        din_last  = ($urandom_range(0, 3) == 0);
        sqz_req   = ($urandom_range(0, 9) < 3);
        if (c == 700) begin
          arstn = 1'b1;
          #2 arstn = 1'b0;
        end
      end
      @(posedge clk); #1;
      clear_inputs();
      repeat (5) @(posedge clk);
    end
    check("rand_pulses_r1", dv_cnt[0] > 20, 1'b1);
    check("rand_pulses_r2", dv_cnt[1] > 20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
